// File: rtl/rc4_ksa_shuffle_ctrl.sv
// rc4_ksa_shuffle_ctrl
// RC4 key-scheduling (KSA) shuffle controller. For i = 0..DEPTH-1 it computes
// j = j + S[i] + key[i mod klen] and swaps S[i] and S[j]. It drives the S and
// key memory ports (synchronous, read latency 1) and tracks i, j and the key
// index k itself. A start/fin handshake links it to the top-level sequencer.
//
// Parameters:
//   ADDR_W        S address/data width, DEPTH = 2**ADDR_W
//   MAX_KEY_BYTES key memory depth; key_len of 0 or above it selects this value
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      level request, accepted only while idle
//   key_len    key length in bytes, sampled when start is accepted
//   busy       high whenever the controller is not idle
//   fin        one-cycle completion pulse
//   key_addr   key memory read address
//   key_rdata  key byte, resized to ADDR_W
//   s_addr     S memory address
//   s_wdata    S memory write data
//   s_wren     S memory write enable
//   s_rdata    S memory read data
//
// Build option:
//   KSA_SKIP_SELF_SWAP_EN  when defined, an iteration whose new j equals i
//                          skips the read-back and both writes (4 cycles).
module rc4_ksa_shuffle_ctrl #(
  parameter  int unsigned ADDR_W        = 8,
  parameter  int unsigned MAX_KEY_BYTES = 3,
  localparam int unsigned KEY_IDX_W     = (MAX_KEY_BYTES > 2) ? $clog2(MAX_KEY_BYTES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_IDX_W:0]   key_len,
  output logic                 busy,
  output logic                 fin,
  output logic [KEY_IDX_W-1:0] key_addr,
  input  logic [7:0]           key_rdata,
  output logic [ADDR_W-1:0]    s_addr,
  output logic [ADDR_W-1:0]    s_wdata,
  output logic                 s_wren,
  input  logic [ADDR_W-1:0]    s_rdata
);

  localparam logic [KEY_IDX_W:0] KLEN_MAX = (KEY_IDX_W+1)'(MAX_KEY_BYTES);
  localparam logic [KEY_IDX_W:0] KLEN_ONE = (KEY_IDX_W+1)'(1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SI  = 4'd1,
    WT_SI  = 4'd2,
    CALC_J = 4'd3,
    RD_SJ  = 4'd4,
    WT_SJ  = 4'd5,
    WR_SI  = 4'd6,
    WR_SJ  = 4'd7,
    INC    = 4'd8,
    DONE   = 4'd9
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    i_q, i_d;
  logic [ADDR_W-1:0]    j_q, j_d;
  logic [ADDR_W-1:0]    si_q, si_d;
  logic [ADDR_W-1:0]    sj_q, sj_d;
  logic [ADDR_W-1:0]    kb_q, kb_d;
  logic [KEY_IDX_W-1:0] k_q, k_d;
  logic [KEY_IDX_W:0]   klen_q, klen_d;

  logic                 busy_q, busy_d;
  logic                 fin_q, fin_d;
  logic                 s_wren_q, s_wren_d;
  logic [ADDR_W-1:0]    s_addr_q, s_addr_d;
  logic [ADDR_W-1:0]    s_wdata_q, s_wdata_d;
  logic [KEY_IDX_W-1:0] key_addr_q, key_addr_d;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      kb_q       <= '0;
      k_q        <= '0;
      klen_q     <= KLEN_MAX;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      s_wren_q   <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      key_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      kb_q       <= kb_d;
      k_q        <= k_d;
      klen_q     <= klen_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      s_wren_q   <= s_wren_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      key_addr_q <= key_addr_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered ports line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    kb_d       = kb_q;
    k_d        = k_q;
    klen_d     = klen_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    key_addr_d = key_addr_q;
    s_wren_d   = 1'b0;
    busy_d     = 1'b0;
    fin_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d  = ((key_len == '0) || (key_len > KLEN_MAX)) ? KLEN_MAX : key_len;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = RD_SI;
        end
      end
      RD_SI:  state_d = WT_SI;
      WT_SI: begin
        si_d    = s_rdata;
        kb_d    = ADDR_W'(key_rdata);
        state_d = CALC_J;
      end
      CALC_J: begin
        j_d     = j_q + si_q + kb_q;
        state_d = RD_SJ;
`ifdef KSA_SKIP_SELF_SWAP_EN
        // Self-swap leaves S unchanged, so skip the memory traffic.
        if (j_d == i_q) begin
          state_d = INC;
        end
`endif
      end
      RD_SJ:  state_d = WT_SJ;
      WT_SJ: begin
        sj_d    = s_rdata;
        state_d = WR_SI;
      end
      WR_SI:  state_d = WR_SJ;
      WR_SJ:  state_d = INC;
      INC: begin
        if (&i_q) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          // Key index wraps by compare against the latched length.
          k_d     = ({1'b0, k_q} == (klen_q - KLEN_ONE)) ? '0 : k_q + KEY_IDX_W'(1);
          state_d = RD_SI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      RD_SI: begin
        s_addr_d   = i_d;
        key_addr_d = k_d;
      end
      RD_SJ: s_addr_d = j_d;
      WR_SI: begin
        s_addr_d  = i_q;
        s_wdata_d = sj_d;
        s_wren_d  = 1'b1;
      end
      WR_SJ: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
    fin_d  = (state_d == DONE);
  end

  assign busy     = busy_q;
  assign fin      = fin_q;
  assign s_wren   = s_wren_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign key_addr = key_addr_q;

endmodule

// File: tb/tb_rc4_ksa_shuffle_ctrl.sv
// Bench for rc4_ksa_shuffle_ctrl (default build, ADDR_W=8, MAX_KEY_BYTES=3).
// A software KSA model yields the per-iteration j and swap data; a per-cycle
// compare process checks the DUT ports against the 8-cycle iteration schedule.
module tb_rc4_ksa_shuffle_ctrl;

  localparam int DEPTH = 256;
  localparam int MAXK  = 3;
  localparam int KW    = 2;
  localparam int LAST  = 8 * DEPTH + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW:0]   key_len;
  logic          busy;
  logic          fin;
  logic [KW-1:0] key_addr;
  logic [7:0]    key_rdata;
  logic [7:0]    s_addr;
  logic [7:0]    s_wdata;
  logic          s_wren;
  logic [7:0]    s_rdata;

  rc4_ksa_shuffle_ctrl #(.ADDR_W(8), .MAX_KEY_BYTES(MAXK)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_len   (key_len),
    .busy      (busy),
    .fin       (fin),
    .key_addr  (key_addr),
    .key_rdata (key_rdata),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wren    (s_wren),
    .s_rdata   (s_rdata)
  );

  always #5 clk = ~clk;

  // Memories: synchronous read, latency 1
  logic [7:0] s_mem    [DEPTH];
  logic [7:0] load_img [DEPTH];
  logic [7:0] key_mem  [4];
  logic       load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int n = 0; n < DEPTH; n++) s_mem[n] <= load_img[n];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wdata;
    end
    s_rdata   <= s_mem[s_addr];
    key_rdata <= key_mem[key_addr];
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model
  int         exp_j  [DEPTH];
  int         exp_si [DEPTH];
  int         exp_sj [DEPTH];
  logic [7:0] exp_fin[DEPTH];
  logic [7:0] t2_fin [DEPTH];
  int         m_klen = MAXK;

  function automatic int eff_klen(input int kl);
    return (kl == 0 || kl > MAXK) ? MAXK : kl;
  endfunction

  task automatic build_model(input int klen_eff);
    int s [DEPTH];
    int j;
    int si;
    int sj;
    for (int n = 0; n < DEPTH; n++) s[n] = int'(load_img[n]);
    j = 0;
    for (int i = 0; i < DEPTH; i++) begin
      si = s[i];
      j  = (j + si + int'(key_mem[i % klen_eff])) % DEPTH;
      sj = s[j];
      exp_j[i]  = j;
      exp_si[i] = si;
      exp_sj[i] = sj;
      s[i] = sj;
      s[j] = si;
    end
    for (int n = 0; n < DEPTH; n++) exp_fin[n] = 8'(s[n]);
    m_klen = klen_eff;
  endtask

  function automatic logic [31:0] outv();
    return {11'b0, busy, fin, s_wren, s_addr, s_wdata, key_addr};
  endfunction

  // Cycle and fin bookkeeping
  int gcyc = 0;
  int fin_q[$];
  always @(posedge clk) gcyc <= gcyc + 1;
  always @(negedge clk) if (fin) fin_q.push_back(gcyc);

  // Per-cycle compare against the iteration schedule
  logic tracking = 1'b0;
  int   pin_mode = 0;
  int   cyc      = 0;
  int   wren_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (tracking) begin
      int it;
      int ph;
      logic [31:0] e;
      logic [31:0] m;
      cyc++;
      if (cyc == 1) wren_cnt = 0;
      if (s_wren) wren_cnt++;
      it = (cyc - 1) / 8;
      ph = (cyc - 1) % 8;
      e = 32'h0;
      m = 32'h001C_0000;
      if (cyc == LAST) begin
        e = 32'h0018_0000;
      end else if (cyc > LAST) begin
        e = 32'h0;
      end else begin
        e = 32'h0010_0000;
        case (ph)
          0: begin
            e = e | (32'(it) << 10) | 32'(it % m_klen);
            m = m | 32'h0003_FC03;
          end
          3: begin
            e = e | (32'(exp_j[it]) << 10);
            m = m | 32'h0003_FC00;
          end
          5: begin
            e = e | 32'h0004_0000 | (32'(it) << 10) | (32'(exp_sj[it]) << 2);
            m = m | 32'h0003_FFFC;
          end
          6: begin
            e = e | 32'h0004_0000 | (32'(exp_j[it]) << 10) | (32'(exp_si[it]) << 2);
            m = m | 32'h0003_FFFC;
          end
          default: ;
        endcase
      end
      chk($sformatf("cycle%0d", cyc), outv() & m, e & m);
      if (pin_mode == 1 && cyc == 8)
        chk("t1_after_i0", {16'h0, s_mem[0], s_mem[1]}, 32'h0000_0100);
      if (pin_mode == 1 && cyc == 16)
        chk("t1_after_i1", {16'h0, s_mem[1], s_mem[2]}, 32'h0000_0200);
    end else begin
      cyc = 0;
    end
  end

  task automatic load_identity();
    for (int n = 0; n < DEPTH; n++) load_img[n] = 8'(n);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  int acc_cyc = 0;

  task automatic start_run(input int kl);
    key_len = (KW+1)'(kl);
    build_model(eff_klen(kl));
    acc_cyc  = gcyc;
    tracking = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int nbad;
    for (int n = 0; n < LAST + 100 && cyc != LAST + 1; n++) @(negedge clk);
    chk({name, "_complete"}, 32'(cyc), 32'(LAST + 1));
    tracking = 1'b0;
    nbad = 0;
    for (int n = 0; n < DEPTH; n++) if (s_mem[n] !== exp_fin[n]) nbad++;
    chk({name, "_final_S"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int nbad;
    reset   = 1'b0;
    start   = 1'b0;
    key_len = '0;
    load_en = 1'b0;
    for (int n = 0; n < 4; n++) key_mem[n] = 8'h00;
    #2;
    chk("reset_outputs", outv(), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Test 1: identity S, key_len=1, key 01
    key_mem[0] = 8'h01;
    load_identity();
    f0 = fin_q.size();
    pin_mode = 1;
    start_run(1);
    chk("model_j0", 32'(exp_j[0]), 32'd1);
    chk("model_j1", 32'(exp_j[1]), 32'd2);
    finish_run("t1");
    pin_mode = 0;
    chk("t1_fin_count", 32'(fin_q.size() - f0), 32'd1);
    if (fin_q.size() > f0) chk("t1_fin_cycle", 32'(fin_q[f0] - acc_cyc), 32'd2049);

    // Test 2: key 00 02 49, key_len=3, extra start while busy
    key_mem[0] = 8'h00;
    key_mem[1] = 8'h02;
    key_mem[2] = 8'h49;
    load_identity();
    f0 = fin_q.size();
    start_run(3);
    chk("model_t2_j0", 32'(exp_j[0]), 32'd0);
    chk("model_t2_j1", 32'(exp_j[1]), 32'd3);
    chk("model_t2_j2", 32'(exp_j[2]), 32'd78);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("t2");
    chk("t2_wren_cycles", 32'(wren_cnt), 32'd512);
    chk("t2_fin_count", 32'(fin_q.size() - f0), 32'd1);
    for (int n = 0; n < DEPTH; n++) t2_fin[n] = exp_fin[n];

    // Test 3: key_len=0 selects full key length
    load_identity();
    start_run(0);
    finish_run("t3");
    nbad = 0;
    for (int n = 0; n < DEPTH; n++) if (s_mem[n] !== t2_fin[n]) nbad++;
    chk("t3_equals_t2", 32'(nbad), 32'd0);

    // Test 4: key_len above the maximum selects full key length
    load_identity();
    start_run(7);
    finish_run("t4");
    nbad = 0;
    for (int n = 0; n < DEPTH; n++) if (s_mem[n] !== t2_fin[n]) nbad++;
    chk("t4_equals_t2", 32'(nbad), 32'd0);

    // Test 5: reset at cycle 700, then a fresh run
    load_identity();
    f0 = fin_q.size();
    start_run(3);
    for (int n = 0; n < 2000 && cyc < 700; n++) @(negedge clk);
    chk("t5_reached_700", 32'(cyc), 32'd700);
    tracking = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_reset_outputs", outv(), 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_busy_in_reset", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_fin", 32'(fin_q.size() - f0), 32'd0);
    key_mem[0] = 8'h01;
    load_identity();
    start_run(1);
    finish_run("t5_fresh");

    // Test 6: start held high for 3000 cycles
    load_identity();
    f0 = fin_q.size();
    key_len  = (KW+1)'(1);
    acc_cyc  = gcyc;
    start    = 1'b1;
    repeat (3000) @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3000 && (fin_q.size() - f0 < 2 || busy); n++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("t6_fin_count", 32'(fin_q.size() - f0), 32'd2);
    if (fin_q.size() - f0 >= 2) begin
      chk("t6_fin1_cycle", 32'(fin_q[f0] - acc_cyc), 32'd2049);
      chk("t6_fin2_cycle", 32'(fin_q[f0 + 1] - acc_cyc), 32'd4099);
    end
    chk("t6_idle_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_shuffle_ctrl.md
Name: rc4_ksa_shuffle_ctrl

Overview:
- Parametrised RC4 key-scheduling shuffle controller for the decrypt datapath.
- Runs the full KSA swap loop over working memory S: j = j + S[i] + key[i mod key_len], then swap S[i] and S[j], for i = 0..DEPTH-1.
- Owns the S and key memory addresses, write data and write enables, computes j internally, and takes a runtime key length.
- Sits between the S-init fill block and the PRGA decrypt block; start/fin handshake with the top-level sequencer.

Parameters:
- ADDR_W, 8, S address and data width; DEPTH = 2^ADDR_W; S entries are ADDR_W bits wide.
- MAX_KEY_BYTES, 3, key memory depth; KEY_IDX_W = clog2(MAX_KEY_BYTES), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- start  input  1  level; accepted only in IDLE
- key_len  input  KEY_IDX_W+1  key length in bytes; sampled when start is accepted
- busy  output  1  high in every state except IDLE
- fin  output  1  one-cycle pulse in DONE
- key_addr  output  KEY_IDX_W  key memory read address
- key_rdata  input  8  key byte (zero-extended or truncated to ADDR_W)
- s_addr  output  ADDR_W  S address
- s_wdata  output  ADDR_W  S write data
- s_wren  output  1  S write enable
- s_rdata  input  ADDR_W  S read data

Behaviour:
- Memories are synchronous, read latency 1: an address presented in cycle N gives valid rdata in cycle N+1.
- All outputs are registered or decoded from state.
- Reset (asynchronous, reset=0) forces IDLE. Reset values: i=0, j=0, k=0, busy=0, fin=0, s_wren=0, s_addr=0, s_wdata=0, key_addr=0. Takes effect mid-loop with no completion pulse.
- States, one cycle each unless noted:
  - IDLE: wait for start; on start, latch key_len and clear i, j, k.
  - RD_SI: s_addr=i, key_addr=k.
  - WT_SI: capture si <= s_rdata and kb <= key_rdata.
  - CALC_J: j <= (j + si + kb) mod DEPTH.
  - RD_SJ: s_addr=j.
  - WT_SJ: capture sj <= s_rdata.
  - WR_SI: s_addr=i, s_wdata=sj, s_wren=1.
  - WR_SJ: s_addr=j, s_wdata=si, s_wren=1.
  - INC: if i==DEPTH-1 go to DONE; else i<=i+1, k<=(k==klen-1)?0:k+1, go to RD_SI.
  - DONE: fin=1 for this cycle, then IDLE.
- Arithmetic: all j sums wrap modulo 2^ADDR_W. k wraps via a compare, with no divider.
- key_len=0 or key_len>MAX_KEY_BYTES: treated as MAX_KEY_BYTES (klen).
- i==j: the normal path still performs both writes. The second write stores the original S[i], so the data is unchanged.
- start high while busy: ignored. start held high through DONE: a new run starts from the IDLE cycle that follows.
- key_len changes while busy: ignored.
- Latency: 8 cycles per i; fin is asserted in the 8*DEPTH+1-th cycle after the start-accept edge (2049 for ADDR_W=8).
- s_wren is never high outside WR_SI and WR_SJ.

Optional Feature:
- Macro: KSA_SKIP_SELF_SWAP_EN.
- Defined: after CALC_J, if the new j equals i, go directly to INC and skip RD_SJ, WT_SJ, WR_SI and WR_SJ. That iteration takes 4 cycles, and no S write occurs for it.
- Undefined: the fixed 8-cycle iteration, with i==j handled by the normal path.

Test Plan:
- Identity S (S[n]=n), key_len=1, key[0]=0x01, start pulse:
  - After i=0: S[0]=1, S[1]=0.
  - After i=1: j=2, S[1]=2, S[2]=0.
  - fin pulses exactly once, at cycle 2049.
- Identity S, key_len=3, key=00 02 49: final S matches the software KSA model byte-for-byte. key_addr follows 0,1,2,0,... and s_wren is high exactly 512 cycles.
- key_len=0 with MAX_KEY_BYTES=3: result is identical to the key_len=3 run.
- Drop reset low at cycle 700 of a run: all outputs go to reset values immediately with no fin. A fresh start then completes normally.
- start asserted again while busy, and start held high for 3000 cycles: exactly one run per IDLE entry, with no extra fin.
- With KSA_SKIP_SELF_SWAP_EN, identity S, key_len=1, key[0]=0x00:
  - i=0 and i=1 each take 4 cycles with no writes.
  - i=2 swaps S[2]/S[3] to give 3,2.
  - Total cycle count drops by 4 per self-swap.
